// File: rtl/writeback_unit_pkg.sv
// Shared widths, FSM encoding, captured-bundle layout and helpers for the writeback unit.
package writeback_unit_pkg;

    localparam int unsigned WORD  = 16;
    localparam int unsigned REG_W = 3;

    // Status flag bit positions; the writeback unit treats SREG as opaque.
    localparam int unsigned Zf = 0;
    localparam int unsigned Cf = 1;
    localparam int unsigned Nf = 2;
    localparam int unsigned If = 3;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_APPLY = 2'd1,
        WB_MEM   = 2'd2,
        WB_PCUPD = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic             reg_wb;
        logic [REG_W-1:0] reg_code;
        logic [WORD-1:0]  reg_val;
        logic             flag_update;
        logic [WORD-1:0]  sreg_val;
        logic             mem_wb;
        logic [WORD-1:0]  mem_addr;
        logic [WORD-1:0]  mem_val;
        logic             jump;
        logic             rjump;
        logic [WORD-1:0]  jump_loc;
        logic [WORD-1:0]  jump_inc;
        logic [1:0]       instr_len;
    } wb_bundle_t;

    // A zero instruction length is treated as a single-word instruction.
    function automatic logic [1:0] eff_len(input logic [1:0] len);
        return (len == 2'd0) ? 2'd1 : len;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle, register-file, memory and architectural-state signals of the writeback unit.
interface writeback_unit_if
    import writeback_unit_pkg::*;
;
    logic             ex_valid;
    logic             ex_ready;
    logic             reg_wb;
    logic [REG_W-1:0] reg_write_code;
    logic [WORD-1:0]  reg_write_val;
    logic             flag_update;
    logic [WORD-1:0]  SREG_in_ex;
    logic             mem_wb;
    logic [WORD-1:0]  mem_write_addr;
    logic [WORD-1:0]  mem_write_val;
    logic             jump;
    logic             rjump;
    logic [WORD-1:0]  PC_jump_loc;
    logic [WORD-1:0]  PC_jump_inc;
    logic [1:0]       instr_len;
    logic             rf_we;
    logic [REG_W-1:0] rf_waddr;
    logic [WORD-1:0]  rf_wdata;
    logic             mem_req;
    logic [WORD-1:0]  mem_addr;
    logic [WORD-1:0]  mem_data;
    logic             mem_ack;
    logic [WORD-1:0]  SREG;
    logic [WORD-1:0]  PC;
    logic             wb_done;
    logic             wb_err;

    // Environment side: execute stage, register file, memory.
    modport master (
        output ex_valid, reg_wb, reg_write_code, reg_write_val, flag_update, SREG_in_ex,
               mem_wb, mem_write_addr, mem_write_val, jump, rjump, PC_jump_loc,
               PC_jump_inc, instr_len, mem_ack,
        input  ex_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_data,
               SREG, PC, wb_done, wb_err
    );

    // Writeback unit side.
    modport slave (
        input  ex_valid, reg_wb, reg_write_code, reg_write_val, flag_update, SREG_in_ex,
               mem_wb, mem_write_addr, mem_write_val, jump, rjump, PC_jump_loc,
               PC_jump_inc, instr_len, mem_ack,
        output ex_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_data,
               SREG, PC, wb_done, wb_err
    );

endinterface

// File: rtl/writeback_unit_pc_next.sv
// Combinational next-PC selector: absolute jump beats relative jump beats sequential.
module wb_pc_next
    import writeback_unit_pkg::*;
(
    input  logic [WORD-1:0] pc,
    input  logic            jump,
    input  logic            rjump,
    input  logic [WORD-1:0] jump_loc,
    input  logic [WORD-1:0] jump_inc,
    input  logic [1:0]      instr_len,
    output logic [WORD-1:0] pc_next
);

    // Priority select; additions wrap naturally at WORD bits.
    always_comb begin
        if (jump) begin
            pc_next = jump_loc;
        end else if (rjump) begin
            pc_next = pc + jump_inc;
        end else begin
            pc_next = pc + {{(WORD-2){1'b0}}, eff_len(instr_len)};
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Retirement stage: commits register file, SREG, memory write, then PC, and pulses wb_done.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter logic [WORD-1:0] PC_RESET    = 16'h0000,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input logic             clk,
    input logic             rst_n,
    writeback_unit_if.slave bus
);

    localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

    wb_state_e        state_q, state_d;
    wb_bundle_t       bundle_q, bundle_d;
    logic             rf_we_q, rf_we_d;
    logic [REG_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [WORD-1:0]  rf_wdata_q, rf_wdata_d;
    logic             mem_req_q, mem_req_d;
    logic [WORD-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD-1:0]  mem_data_q, mem_data_d;
    logic [WORD-1:0]  sreg_q, sreg_d;
    logic [WORD-1:0]  pc_q, pc_d;
    logic             wb_done_q, wb_done_d;
    logic             wb_err_q, wb_err_d;
    logic             ex_ready_q, ex_ready_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WORD-1:0]  pc_next;

    wb_pc_next u_pc_next (
        .pc        (pc_q),
        .jump      (bundle_q.jump),
        .rjump     (bundle_q.rjump),
        .jump_loc  (bundle_q.jump_loc),
        .jump_inc  (bundle_q.jump_inc),
        .instr_len (bundle_q.instr_len),
        .pc_next   (pc_next)
    );

    // Next-state and registered-output logic for the commit sequence.
    always_comb begin
        state_d    = state_q;
        bundle_d   = bundle_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        sreg_d     = sreg_q;
        pc_d       = pc_q;
        wb_done_d  = 1'b0;
        wb_err_d   = wb_err_q;
        ex_ready_d = ex_ready_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            WB_IDLE: begin
                if (bus.ex_valid) begin
                    bundle_d.reg_wb      = bus.reg_wb;
                    bundle_d.reg_code    = bus.reg_write_code;
                    bundle_d.reg_val     = bus.reg_write_val;
                    bundle_d.flag_update = bus.flag_update;
                    bundle_d.sreg_val    = bus.SREG_in_ex;
                    bundle_d.mem_wb      = bus.mem_wb;
                    bundle_d.mem_addr    = bus.mem_write_addr;
                    bundle_d.mem_val     = bus.mem_write_val;
                    bundle_d.jump        = bus.jump;
                    bundle_d.rjump       = bus.rjump;
                    bundle_d.jump_loc    = bus.PC_jump_loc;
                    bundle_d.jump_inc    = bus.PC_jump_inc;
                    bundle_d.instr_len   = bus.instr_len;
                    // Register write is presented during the APPLY cycle itself.
                    rf_we_d    = bus.reg_wb;
                    rf_waddr_d = bus.reg_write_code;
                    rf_wdata_d = bus.reg_write_val;
                    ex_ready_d = 1'b0;
                    state_d    = WB_APPLY;
                end
            end
            WB_APPLY: begin
                if (bundle_q.flag_update) begin
                    sreg_d = bundle_q.sreg_val;
                end
                cnt_d = '0;
                if (bundle_q.mem_wb) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = bundle_q.mem_addr;
                    mem_data_d = bundle_q.mem_val;
                    state_d    = WB_MEM;
                end else begin
                    state_d = WB_PCUPD;
                end
            end
            WB_MEM: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = WB_PCUPD;
                end else if ((MEM_TIMEOUT != 0) && (cnt_d == TimeoutCnt)) begin
                    mem_req_d = 1'b0;
                    wb_err_d  = 1'b1;
                    state_d   = WB_PCUPD;
                end
            end
            WB_PCUPD: begin
                pc_d       = pc_next;
                wb_done_d  = 1'b1;
                ex_ready_d = 1'b1;
                state_d    = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // State and output registers; reset abandons any bundle in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WB_IDLE;
            bundle_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            sreg_q     <= '0;
            pc_q       <= PC_RESET;
            wb_done_q  <= 1'b0;
            wb_err_q   <= 1'b0;
            ex_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bundle_q   <= bundle_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            sreg_q     <= sreg_d;
            pc_q       <= pc_d;
            wb_done_q  <= wb_done_d;
            wb_err_q   <= wb_err_d;
            ex_ready_q <= ex_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ex_ready = ex_ready_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.SREG     = sreg_q;
    assign bus.PC       = pc_q;
    assign bus.wb_done  = wb_done_q;
    assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table plus memory, timeout, back-to-back, reset cases.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    typedef struct {
        logic        reg_wb;
        logic [2:0]  code;
        logic [15:0] val;
        logic        flag;
        logic [15:0] sreg_in;
        logic        mem_wb;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic        jump;
        logic        rjump;
        logic [15:0] loc;
        logic [15:0] inc;
        logic [1:0]  len;
        logic [15:0] exp_pc;
        logic [15:0] exp_sreg;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic exp_err;
    vec_t vecs[10];
    vec_t v;

    writeback_unit_if bus ();

    writeback_unit #(
        .PC_RESET    (16'h0000),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bus.reg_wb         = x.reg_wb;
        bus.reg_write_code = x.code;
        bus.reg_write_val  = x.val;
        bus.flag_update    = x.flag;
        bus.SREG_in_ex     = x.sreg_in;
        bus.mem_wb         = x.mem_wb;
        bus.mem_write_addr = x.maddr;
        bus.mem_write_val  = x.mdata;
        bus.jump           = x.jump;
        bus.rjump          = x.rjump;
        bus.PC_jump_loc    = x.loc;
        bus.PC_jump_inc    = x.inc;
        bus.instr_len      = x.len;
    endtask

    // Garbage on the bundle after capture must not leak into the commit.
    task automatic scramble();
        bus.reg_wb         = 1'b1;
        bus.reg_write_code = 3'h5;
        bus.reg_write_val  = 16'hFFFF;
        bus.flag_update    = 1'b1;
        bus.SREG_in_ex     = 16'hFFFF;
        bus.mem_wb         = 1'b1;
        bus.mem_write_addr = 16'hFFFF;
        bus.mem_write_val  = 16'hFFFF;
        bus.jump           = 1'b1;
        bus.rjump          = 1'b1;
        bus.PC_jump_loc    = 16'hFFFF;
        bus.PC_jump_inc    = 16'hFFFF;
        bus.instr_len      = 2'd3;
    endtask

    // Called at a negedge in IDLE; returns at the negedge where wb_done is seen.
    task automatic run(input vec_t x, input int ack_cycle, input int exp_req, input int exp_lat);
        int lat;
        int req_cycles;
        chk("ex_ready_idle", 32'(bus.ex_ready), 32'd1);
        drive(x);
        bus.ex_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        scramble();
        lat = 0;
        req_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            // Ack during APPLY must be ignored.
            bus.mem_ack = (n == 1) || (n == ack_cycle);
            if (n == 1) begin
                chk("apply_rf_we", 32'(bus.rf_we), 32'(x.reg_wb));
                if (x.reg_wb) begin
                    chk("apply_rf_waddr", 32'(bus.rf_waddr), 32'(x.code));
                    chk("apply_rf_wdata", 32'(bus.rf_wdata), 32'(x.val));
                end
                chk("apply_ex_ready", 32'(bus.ex_ready), 32'd0);
                chk("apply_mem_req", 32'(bus.mem_req), 32'd0);
            end
            if (bus.mem_req) begin
                req_cycles++;
                chk("mem_addr", 32'(bus.mem_addr), 32'(x.maddr));
                chk("mem_data", 32'(bus.mem_data), 32'(x.mdata));
            end
            if (bus.wb_done) begin
                lat = n;
                break;
            end
        end
        bus.mem_ack = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("mem_req_cycles", 32'(req_cycles), 32'(exp_req));
        chk("pc", 32'(bus.PC), 32'(x.exp_pc));
        chk("sreg", 32'(bus.SREG), 32'(x.exp_sreg));
        chk("wb_err", 32'(bus.wb_err), 32'(exp_err));
        chk("done_ex_ready", 32'(bus.ex_ready), 32'd1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_err = 1'b0;
        rst_n = 1'b0;
        bus.ex_valid = 1'b0;
        bus.mem_ack = 1'b0;
        scramble();

        //          rwb  code  val      flg  sreg_in   mwb  maddr  mdata  jmp  rjmp loc       inc       len   pc        sreg
        vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h000A, 16'h0000, 2'd1, 16'h000A, 16'h0000};
        vecs[1] = '{1'b1, 3'd3, 16'h0042, 1'b1, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1, 16'h000B, 16'h0002};
        vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'hDEAD, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'd1, 16'h0040, 16'h0002};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'd1, 16'h0005, 16'h0002};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0000, 16'hFFFD, 2'd1, 16'h0002, 16'h0002};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'd1, 16'hFFFF, 16'h0002};
        vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd2, 16'h0001, 16'h0002};
        vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h1234, 16'h0010, 2'd1, 16'h1234, 16'h0002};
        vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 16'h1235, 16'h0002};
        vecs[9] = '{1'b1, 3'd7, 16'hA5A5, 1'b1, 16'h8001, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0000, 16'h0100, 2'd2, 16'h1335, 16'h8001};

        // Reset state.
        #12;
        chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("rst_rf", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'd0);
        chk("rst_mem", 32'({bus.mem_req, bus.mem_addr, bus.mem_data}), 32'd0);
        chk("rst_sreg_pc", 32'({bus.SREG, bus.PC}), 32'd0);
        chk("rst_done_err", 32'({bus.wb_done, bus.wb_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i], 0, 0, 3);
        end

        // Memory write with ack sampled at the end of the fourth MEM cycle.
        v = '{1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0,
              2'd1, 16'h1336, 16'h8001};
        run(v, 5, 4, 7);

        // Ack never arrives: timeout after 15 MEM cycles, error is sticky.
        v = '{1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0,
              2'd1, 16'h1337, 16'h8001};
        exp_err = 1'b1;
        run(v, 0, 15, 18);

        // Back-to-back: ex_valid held, second bundle accepted in the wb_done cycle.
        begin
            int rf_pulses;
            int done_pulses;
            v = '{1'b1, 3'd1, 16'h1111, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                  2'd1, 16'h0, 16'h0};
            drive(v);
            bus.ex_valid = 1'b1;
            @(posedge clk);
            #1;
            v = '{1'b1, 3'd2, 16'h2222, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0200,
                  16'h0, 2'd1, 16'h0, 16'h0};
            drive(v);
            rf_pulses = 0;
            done_pulses = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (bus.rf_we) rf_pulses++;
                if (bus.wb_done) done_pulses++;
                if (n == 1) chk("b2b_rf_a", 32'({bus.rf_waddr, bus.rf_wdata}), 32'({3'd1, 16'h1111}));
                if (n == 4) chk("b2b_rf_b", 32'({bus.rf_waddr, bus.rf_wdata}), 32'({3'd2, 16'h2222}));
                if (n == 1 || n == 2 || n == 4 || n == 5) chk("b2b_busy", 32'(bus.ex_ready), 32'd0);
                if (n == 3) begin
                    chk("b2b_done_a", 32'({bus.wb_done, bus.ex_ready}), 32'd3);
                    chk("b2b_pc_a", 32'(bus.PC), 32'h1338);
                    @(posedge clk);
                    #1;
                    bus.ex_valid = 1'b0;
                    scramble();
                end
                if (n == 6) begin
                    chk("b2b_done_b", 32'(bus.wb_done), 32'd1);
                    chk("b2b_pc_b", 32'(bus.PC), 32'h0200);
                end
            end
            chk("b2b_rf_pulses", 32'(rf_pulses), 32'd2);
            chk("b2b_done_pulses", 32'(done_pulses), 32'd2);
            chk("b2b_err_sticky", 32'(bus.wb_err), 32'd1);
        end

        // Reset while a memory write is outstanding.
        begin
            logic seen;
            v = '{1'b1, 3'd4, 16'h4444, 1'b1, 16'h5555, 1'b1, 16'h0300, 16'h7777, 1'b0, 1'b0,
                  16'h0, 16'h0, 2'd1, 16'h0, 16'h0};
            drive(v);
            bus.ex_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.ex_valid = 1'b0;
            scramble();
            seen = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (bus.mem_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rstmid_req_seen", 32'(seen), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("rstmid_req_we_done", 32'({bus.mem_req, bus.rf_we, bus.wb_done}), 32'd0);
            chk("rstmid_pc", 32'(bus.PC), 32'h0000);
            chk("rstmid_sreg", 32'(bus.SREG), 32'h0000);
            chk("rstmid_err", 32'(bus.wb_err), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rstmid_ready", 32'(bus.ex_ready), 32'd1);
            chk("rstmid_req_after", 32'(bus.mem_req), 32'd0);
            exp_err = 1'b0;
            v = '{1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                  2'd1, 16'h0001, 16'h0000};
            run(v, 0, 0, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Retirement stage that sits after the execute stage and consumes its result bundle.
- The bundle holds: register write, memory write, SREG update, and jump/rjump.
- The block commits the bundle in a fixed order: register file, SREG, memory (req/ack handshake), then PC.
- It signals completion back to the fetch/execute sequencer with a one-cycle pulse.

Parameters:
- WORD, 16, datapath/address/PC width.
- REG_W, 3, register code width.
- PC_RESET, 16'h0000, PC value after reset.
- MEM_TIMEOUT, 15, maximum number of cycles to wait for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  result bundle valid.
- ex_ready  out  1  unit can accept a bundle; high only in IDLE.
- reg_wb  in  1  commit a register write.
- reg_write_code  in  REG_W  destination register.
- reg_write_val  in  WORD  register data.
- flag_update  in  1  commit SREG_in_ex.
- SREG_in_ex  in  WORD  new status value.
- mem_wb  in  1  commit a memory write.
- mem_write_addr  in  WORD  memory address.
- mem_write_val  in  WORD  memory data.
- jump  in  1  absolute jump.
- rjump  in  1  relative jump.
- PC_jump_loc  in  WORD  absolute target.
- PC_jump_inc  in  WORD  signed relative offset.
- instr_len  in  2  length in words of the retiring instruction (1 or 2).
- rf_we  out  1  register file write enable.
- rf_waddr  out  REG_W  register file address.
- rf_wdata  out  WORD  register file data.
- mem_req  out  1  memory write request.
- mem_addr  out  WORD  memory address.
- mem_data  out  WORD  memory data.
- mem_ack  in  1  memory write accepted.
- SREG  out  WORD  architectural status register.
- PC  out  WORD  architectural program counter.
- wb_done  out  1  one-cycle retirement pulse.
- wb_err  out  1  sticky memory-timeout error.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, ex_ready=1 (after exiting reset)
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - mem_req=0, mem_addr=0, mem_data=0
  - SREG=0, PC=PC_RESET, wb_done=0, wb_err=0, timeout counter=0
- Reset mid-operation aborts the bundle; nothing partially committed after reset is retained.
- All outputs are registered.
- FSM states: IDLE, APPLY, MEM, PCUPD.
- IDLE:
  - ex_ready=1.
  - On ex_valid at an edge, capture the whole bundle into internal registers and go to APPLY.
  - Bundle inputs are don't-care after capture.
- APPLY (exactly 1 cycle):
  - rf_we = captured reg_wb; rf_waddr and rf_wdata driven from the captured bundle.
  - If flag_update, SREG <= SREG_in_ex at the end of the cycle.
  - Next state is MEM if mem_wb, else PCUPD.
- MEM:
  - mem_req=1, with mem_addr/mem_data stable until the cycle mem_ack is sampled high; mem_req drops the next cycle.
  - Counter increments each MEM cycle.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no ack: drop mem_req, set wb_err=1 (sticky until reset), continue to PCUPD.
  - mem_ack outside MEM is ignored.
- PCUPD (1 cycle), PC selection, all arithmetic mod 2^WORD:
  - jump → PC_jump_loc.
  - else rjump → PC + PC_jump_inc.
  - else PC + instr_len.
  - jump and rjump both set: jump wins.
  - instr_len=0 is treated as 1.
  - wb_done=1 for the following cycle, in IDLE, with the new PC already visible.
- Latency from the accept edge to wb_done high:
  - no memory write: 3 cycles.
  - with memory write: 3 + number of MEM cycles.
- A new bundle may be accepted in the same cycle wb_done is high.
- ex_valid while ex_ready=0 is not accepted; the producer must hold it.
- A bundle with no commit flags still advances PC and pulses wb_done.

Decomposition:
- Shared fmt package/header additions:
  - WORD width and register code width.
  - FSM state encodings: WB_IDLE, WB_APPLY, WB_MEM, WB_PCUPD.
  - Existing flag bit indices (Zf, Cf, Nf, If) stay there; this block treats SREG as opaque.
- One natural sub-module: wb_pc_next, the combinational next-PC selector with priority and wrap.

Test Plan:
- ALU retire: reg_wb=1, code=3, val=16'h0042, flag_update=1, SREG_in_ex=16'h0002, instr_len=1, PC=10 → rf_we pulse with addr 3 and data 0x42 in APPLY; SREG=0x0002; PC=11; wb_done 3 cycles after accept.
- Memory write, ack delayed 4 cycles: addr=0x0100, data=0xBEEF → mem_req held 4 cycles with stable addr/data, then dropped; wb_done at cycle 7; wb_err=0.
- Timeout: MEM_TIMEOUT=15, mem_ack tied low → mem_req drops after 15 cycles; wb_err=1 and stays 1; PC still advances; wb_done pulses.
- Jumps:
  - jump=1, loc=0x0040 → PC=0x0040.
  - rjump, PC=0x0005, inc=16'hFFFD → PC=0x0002.
  - PC=0xFFFF, instr_len=2 → PC=0x0001.
  - jump and rjump both set → absolute target taken.
- Back-to-back: ex_valid held continuously for two bundles → second accepted in the wb_done cycle; ex_ready=0 during APPLY/MEM/PCUPD; no bundle lost or duplicated.
- Reset mid-MEM: assert rst_n=0 while mem_req=1 → mem_req, rf_we, and wb_done go 0 immediately; PC=PC_RESET; SREG=0; after release ex_ready=1.
